// File: rtl/gpio_pad_arbiter_pkg.sv
// Shared definitions for the GPIO pad arbiter.
//   - register address constants for the 4-entry config space
//   - per-group ownership FSM state encoding
//   - width of the TURN (drain length) field
package gpio_pad_arbiter_pkg;

  // Width of the TURN register and of each group's drain counter.
  localparam int unsigned TurnWidth = 4;

  // Bit position of the first busy flag inside STATUS.
  localparam int unsigned BusyLsb = 4;

  // Register map.
  localparam logic [1:0] AddrOwnReq = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrTurn   = 2'd2;
  localparam logic [1:0] AddrDone   = 2'd3;

  // Ownership state of one pad group.
  typedef enum logic [1:0] {
    OWN_SOC = 2'd0,
    DRAIN   = 2'd1,
    OWN_ALT = 2'd2
  } grp_state_e;

endpackage

// File: rtl/gpio_pad_group_ctrl.sv
// Ownership controller for one group of GroupWidth pads.
// Hands the group between the SoC and alternate-function requesters with a
// drain window in between, during which the pads are neither driven nor
// visible to either side.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   own_req           requested owner (1 = alt, 0 = soc)
//   turn              drain length to load on the next drain entry
//   soc_out/soc_oe    SoC drive values for this group
//   alt_out/alt_oe    alternate-function drive values for this group
//   pad_in            pad-to-core values for this group
//   soc_in/alt_in     pad values forwarded to the current owner, 0 otherwise
//   pad_out/pad_oe    registered pad drive (0 while draining)
//   owner             current owner (previous owner while draining)
//   busy              group is draining
//   done_set          one-cycle pulse when a new owner takes over
module gpio_pad_group_ctrl
  import gpio_pad_arbiter_pkg::*;
#(
  parameter int unsigned GroupWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  own_req,
  input  logic [TurnWidth-1:0]  turn,
  input  logic [GroupWidth-1:0] soc_out,
  input  logic [GroupWidth-1:0] soc_oe,
  input  logic [GroupWidth-1:0] alt_out,
  input  logic [GroupWidth-1:0] alt_oe,
  input  logic [GroupWidth-1:0] pad_in,
  output logic [GroupWidth-1:0] soc_in,
  output logic [GroupWidth-1:0] alt_in,
  output logic [GroupWidth-1:0] pad_out,
  output logic [GroupWidth-1:0] pad_oe,
  output logic                  owner,
  output logic                  busy,
  output logic                  done_set
);

  localparam logic [TurnWidth-1:0] CntOne = TurnWidth'(1);

  grp_state_e            state_r, state_s;
  logic [TurnWidth-1:0]  cnt_r, cnt_s;
  logic                  owner_r, owner_s;
  logic                  done_set_s;
  logic [GroupWidth-1:0] pad_out_r, pad_out_s;
  logic [GroupWidth-1:0] pad_oe_r, pad_oe_s;

  // Next-state, drain counter and handover detection.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    owner_s    = owner_r;
    done_set_s = 1'b0;
    case (state_r)
      OWN_SOC: begin
        if (own_req) begin
          state_s = DRAIN;
          // A zero TURN still gives a one-cycle drain.
          cnt_s   = (turn == '0) ? CntOne : turn;
        end else begin
          state_s = OWN_SOC;
        end
      end
      OWN_ALT: begin
        if (!own_req) begin
          state_s = DRAIN;
          cnt_s   = (turn == '0) ? CntOne : turn;
        end else begin
          state_s = OWN_ALT;
        end
      end
      DRAIN: begin
        if (cnt_r <= CntOne) begin
          // The request seen on the last drain cycle decides the new owner;
          // falling back to the old owner is not a handover.
          state_s = own_req ? OWN_ALT : OWN_SOC;
          cnt_s   = '0;
          if (own_req != owner_r) begin
            owner_s    = own_req;
            done_set_s = 1'b1;
          end else begin
            owner_s    = owner_r;
          end
        end else begin
          cnt_s = cnt_r - CntOne;
        end
      end
      default: begin
        state_s = OWN_SOC;
        cnt_s   = '0;
        owner_s = 1'b0;
      end
    endcase
  end

  // Pad drive for the coming cycle follows the state being entered, so the
  // zeroed window lines up exactly with the DRAIN state.
  always_comb begin
    pad_out_s = '0;
    pad_oe_s  = '0;
    case (state_s)
      OWN_SOC: begin
        pad_out_s = soc_out;
        pad_oe_s  = soc_oe;
      end
      OWN_ALT: begin
        pad_out_s = alt_out;
        pad_oe_s  = alt_oe;
      end
      default: begin
        pad_out_s = '0;
        pad_oe_s  = '0;
      end
    endcase
  end

  // Pad-to-core forwarding to the current owner only.
  always_comb begin
    soc_in = '0;
    alt_in = '0;
    case (state_r)
      OWN_SOC: soc_in = pad_in;
      OWN_ALT: alt_in = pad_in;
      default: begin
        soc_in = '0;
        alt_in = '0;
      end
    endcase
  end

  // State, counter, owner and registered pad drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= OWN_SOC;
      cnt_r     <= '0;
      owner_r   <= 1'b0;
      pad_out_r <= '0;
      pad_oe_r  <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      owner_r   <= owner_s;
      pad_out_r <= pad_out_s;
      pad_oe_r  <= pad_oe_s;
    end
  end

  assign pad_out  = pad_out_r;
  assign pad_oe   = pad_oe_r;
  assign owner    = owner_r;
  assign busy     = (state_r == DRAIN);
  assign done_set = done_set_s;

endmodule

// File: rtl/gpio_pad_arbiter.sv
// GPIO pad arbiter: per-group ownership of the pad ring between the SoC GPIO
// block and an alternate-function block, controlled through a small register
// file.
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-high reset
//   cfg_req_i/we_i/addr_i/wdata_i         register access request
//   cfg_rvalid_o/cfg_rdata_o              response, one cycle after request
//   soc_gpio_o/soc_gpio_oe_o/soc_gpio_i   SoC requester (o/oe in, i out)
//   alt_gpio_o/alt_gpio_oe_o/alt_gpio_i   alternate requester (o/oe in, i out)
//   pad_c2p_o/pad_c2p_en_o/pad_p2c_i      pad ring
//   irq_o                                 OR of the DONE bits
// Registers: 0 OWNREQ rw, 1 STATUS ro (owner | busy<<4), 2 TURN rw, 3 DONE w1c.
module gpio_pad_arbiter
  import gpio_pad_arbiter_pkg::*;
#(
  parameter int unsigned GpioCount   = 32,
  parameter int unsigned GroupWidth  = 8,
  parameter int unsigned DefaultTurn = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [1:0]           cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  input  logic [GpioCount-1:0] soc_gpio_o,
  input  logic [GpioCount-1:0] soc_gpio_oe_o,
  output logic [GpioCount-1:0] soc_gpio_i,
  input  logic [GpioCount-1:0] alt_gpio_o,
  input  logic [GpioCount-1:0] alt_gpio_oe_o,
  output logic [GpioCount-1:0] alt_gpio_i,
  output logic [GpioCount-1:0] pad_c2p_o,
  output logic [GpioCount-1:0] pad_c2p_en_o,
  input  logic [GpioCount-1:0] pad_p2c_i,
  output logic                 irq_o
);

  localparam int unsigned NumGroups = GpioCount / GroupWidth;

  logic [NumGroups-1:0] ownreq_r, ownreq_s;
  logic [TurnWidth-1:0] turn_r, turn_s;
  logic [NumGroups-1:0] done_r, done_s;
  logic [NumGroups-1:0] done_clr_s;
  logic [NumGroups-1:0] done_set_s;
  logic [NumGroups-1:0] owner_s;
  logic [NumGroups-1:0] busy_s;
  logic [31:0]          status_s;
  logic [31:0]          rdata_s;
  logic                 rvalid_r;
  logic [31:0]          rdata_r;
  logic                 unused_wdata_s;

  // Only the low bits of write data are meaningful.
  assign unused_wdata_s = ^cfg_wdata_i;

  for (genvar g = 0; g < NumGroups; g++) begin : g_group
    gpio_pad_group_ctrl #(
      .GroupWidth (GroupWidth)
    ) u_ctrl (
      .clk      (clk_i),
      .rst      (rst_i),
      .own_req  (ownreq_r[g]),
      .turn     (turn_r),
      .soc_out  (soc_gpio_o[g*GroupWidth +: GroupWidth]),
      .soc_oe   (soc_gpio_oe_o[g*GroupWidth +: GroupWidth]),
      .alt_out  (alt_gpio_o[g*GroupWidth +: GroupWidth]),
      .alt_oe   (alt_gpio_oe_o[g*GroupWidth +: GroupWidth]),
      .pad_in   (pad_p2c_i[g*GroupWidth +: GroupWidth]),
      .soc_in   (soc_gpio_i[g*GroupWidth +: GroupWidth]),
      .alt_in   (alt_gpio_i[g*GroupWidth +: GroupWidth]),
      .pad_out  (pad_c2p_o[g*GroupWidth +: GroupWidth]),
      .pad_oe   (pad_c2p_en_o[g*GroupWidth +: GroupWidth]),
      .owner    (owner_s[g]),
      .busy     (busy_s[g]),
      .done_set (done_set_s[g])
    );
  end

  // STATUS word assembly.
  always_comb begin
    status_s = 32'd0;
    status_s[NumGroups-1:0]         = owner_s;
    status_s[BusyLsb +: NumGroups]  = busy_s;
  end

  // Register write decode and read mux.
  always_comb begin
    ownreq_s   = ownreq_r;
    turn_s     = turn_r;
    done_clr_s = '0;
    rdata_s    = 32'd0;
    if (cfg_req_i && cfg_we_i) begin
      case (cfg_addr_i)
        AddrOwnReq: ownreq_s   = cfg_wdata_i[NumGroups-1:0];
        AddrTurn:   turn_s     = cfg_wdata_i[TurnWidth-1:0];
        AddrDone:   done_clr_s = cfg_wdata_i[NumGroups-1:0];
        default:    ownreq_s   = ownreq_r;
      endcase
    end else if (cfg_req_i) begin
      case (cfg_addr_i)
        AddrOwnReq: rdata_s[NumGroups-1:0] = ownreq_r;
        AddrStatus: rdata_s                = status_s;
        AddrTurn:   rdata_s[TurnWidth-1:0] = turn_r;
        AddrDone:   rdata_s[NumGroups-1:0] = done_r;
        default:    rdata_s                = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
    // A handover in the same cycle as a clear keeps the bit set.
    done_s = (done_r & ~done_clr_s) | done_set_s;
  end

  // Register file and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ownreq_r <= '0;
      turn_r   <= TurnWidth'(DefaultTurn);
      done_r   <= '0;
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      ownreq_r <= ownreq_s;
      turn_r   <= turn_s;
      done_r   <= done_s;
      rvalid_r <= cfg_req_i;
      rdata_r  <= rdata_s;
    end
  end

  assign cfg_rvalid_o = rvalid_r;
  assign cfg_rdata_o  = rdata_r;
  assign irq_o        = |done_r;

endmodule

// File: doc/gpio_pad_arbiter.md
GPIO_PAD_ARBITER -- requirements
Module: gpio_pad_arbiter

Interface
REQ-001 SHALL have parameter GpioCount, default 32: number of GPIO pads; SHALL be a multiple of GroupWidth.
REQ-002 SHALL have parameter GroupWidth, default 8: pads per ownership group; NumGroups = GpioCount/GroupWidth, 4 by default.
REQ-003 SHALL have parameter DefaultTurn, default 4: reset value of TURN.
REQ-004 SHALL have port clk_i, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have ports cfg_req_i in 1, cfg_we_i in 1, cfg_addr_i in 2, cfg_wdata_i in 32: register access request.
REQ-007 SHALL have ports cfg_rvalid_o out 1, cfg_rdata_o out 32: response, valid one cycle after the request.
REQ-008 SHALL have ports soc_gpio_o in GpioCount, soc_gpio_oe_o in GpioCount, soc_gpio_i out GpioCount: SoC GPIO requester.
REQ-009 SHALL have ports alt_gpio_o in GpioCount, alt_gpio_oe_o in GpioCount, alt_gpio_i out GpioCount: alternate-function requester.
REQ-010 SHALL have ports pad_c2p_o out GpioCount, pad_c2p_en_o out GpioCount, pad_p2c_i in GpioCount: pad-ring side.
REQ-011 SHALL have port irq_o, output, 1: level interrupt, OR of the DONE bits.

Function
REQ-012 Register map SHALL be: 0 OWNREQ rw [NumGroups-1:0], 1=alt 0=soc; 1 STATUS ro, [NumGroups-1:0] current owner and [NumGroups+3:4] group busy; 2 TURN rw [3:0]; 3 DONE w1c [NumGroups-1:0].
REQ-013 Unused register bits SHALL read 0 and ignore writes; every request, read or write, SHALL produce cfg_rvalid_o=1 the next cycle.
REQ-014 Each group SHALL run an FSM with states OWN_SOC, DRAIN, OWN_ALT.
REQ-015 In OWN_x, when OWNREQ[g] selects the other owner, the FSM SHALL go to DRAIN and load a counter with max(TURN,1).
REQ-016 In DRAIN, the group's pad_c2p_o and pad_c2p_en_o SHALL be 0 and the counter SHALL decrement once per cycle.
REQ-017 When the counter reaches 1, the FSM SHALL enter the owner selected by OWNREQ[g] at that cycle; if that is the previous owner, DONE is not set.
REQ-018 On entry into a new owner state, DONE[g] SHALL be set.
REQ-019 A DONE set and a w1c clear in the same cycle SHALL leave the bit set.
REQ-020 OWNREQ changes during DRAIN SHALL NOT restart the counter.
REQ-021 TURN changes SHALL take effect only at the next DRAIN entry.
REQ-022 pad_c2p_o and pad_c2p_en_o SHALL be registered: the owner's o/oe values appear one cycle after sampling; latency is 1.
REQ-023 The owner's *_gpio_i SHALL be combinational pad_p2c_i for the group; the non-owner's *_gpio_i SHALL be 0; during DRAIN both SHALL be 0.
REQ-024 STATUS busy[g] SHALL be 1 exactly while group g is in DRAIN.

Reset
REQ-025 On rst_i=1, asynchronously: all FSMs SHALL be OWN_SOC; OWNREQ=0, DONE=0, TURN=DefaultTurn; counters 0; pad_c2p_o=0, pad_c2p_en_o=0, cfg_rvalid_o=0, cfg_rdata_o=0, irq_o=0.
REQ-026 Reset asserted mid-DRAIN SHALL abort the drain and return the group to OWN_SOC with no DONE.

Structure
REQ-027 A shared package SHALL hold the register address constants, the FSM state enum (OWN_SOC, DRAIN, OWN_ALT), and the TURN width constant.
REQ-028 The per-group FSM, counter and output mux SHALL be one sub-module, gpio_pad_group_ctrl, instantiated NumGroups times.

Verification
REQ-029 Reset with soc_gpio_o=0xA5A5A5A5 and soc_gpio_oe_o=all-ones: the cycle after reset release, pad_c2p_o=0xA5A5A5A5, pad_c2p_en_o=all-ones, and alt_gpio_i=0.
REQ-030 With TURN=3, write OWNREQ=0x2: group1 pads [15:8] c2p/en=0 for exactly 3 cycles, then carry the alt values; DONE=0x2; irq_o=1; STATUS busy1 is high for those 3 cycles.
REQ-031 Write OWNREQ=0x1, then OWNREQ=0x0 mid-drain: the drain completes and group0 returns to SoC; DONE stays 0.
REQ-032 With TURN=0, switch group3: drain lasts 1 cycle.
REQ-033 Write 1 to DONE in the same cycle as a new DONE set: the bit remains 1; a later w1c clears it and irq_o=0.
REQ-034 Assert rst_i during group2's DRAIN: all outputs become 0 immediately and group2 returns to OWN_SOC.
